// File: rtl/digit_scan_pkg.sv
// Shared types and constants for the MC14433-style digit scanner.
// Holds the scan state enum, the captured reading layout and the underrange test.
package mc14433_pkg;

    localparam int NIB_W    = 4;
    localparam int SLOT_DEF = 16;
    localparam int GAP_DEF  = 2;
    localparam int UR_LIMIT = 179;
    localparam int CNT_W    = 8;

    typedef enum logic [3:0] {
        IDLE,
        STB1,
        GAP1,
        STB2,
        GAP2,
        STB3,
        GAP3,
        STB4,
        GAP4
    } scan_state_t;

    typedef struct packed {
        logic             hd;
        logic [NIB_W-1:0] d3;
        logic [NIB_W-1:0] d2;
        logic [NIB_W-1:0] d1;
        logic             pol;
        logic             ovf;
    } reading_t;

    localparam reading_t READING_RST = '{
        hd:  1'b0,
        d3:  4'd0,
        d2:  4'd0,
        d1:  4'd0,
        pol: 1'b1,
        ovf: 1'b0
    };

    // Raw nibble values are weighted as-is, so non-BCD digits still give a magnitude.
    function automatic logic is_underrange(input reading_t r);
        logic [11:0] mag;
        mag = 12'(r.d3) * 12'd100 + 12'(r.d2) * 12'd10 + 12'(r.d1);
        if (r.hd) begin
            mag = mag + 12'd1000;
        end
        return !r.ovf && (mag <= 12'(UR_LIMIT));
    endfunction

endpackage

// File: rtl/digit_scan_if.sv
// Counter-chain inputs and multiplexed display outputs of the digit scanner.
// The master side drives the reading; the slave side is the scanner itself.
interface digit_scan_if;
    import mc14433_pkg::*;

    logic             eoc;
    logic             du;
    logic [NIB_W-1:0] d1b;
    logic [NIB_W-1:0] d2b;
    logic [NIB_W-1:0] d3b;
    logic             hd;
    logic             pol;
    logic             ovf;
    logic [3:0]       q;
    logic [3:0]       ds;
    logic             orb;
    logic             ur;

    modport master (
        output eoc, du, d1b, d2b, d3b, hd, pol, ovf,
        input  q, ds, orb, ur
    );

    modport slave (
        input  eoc, du, d1b, d2b, d3b, hd, pol, ovf,
        output q, ds, orb, ur
    );

endinterface

// File: rtl/digit_scan_timer.sv
// Phase down-counter: load with (length-1) on entry, tc is high on the last cycle.
// The counter parks at zero, so tc stays high until the next load.
module scan_timer
    import mc14433_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         cp,
    input  logic         rb,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge cp) begin
        if (!rb) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/digit_scan.sv
// Four-digit strobe scanner with shadow/display capture and range flags.
// Outputs are decoded from the next state and next display so they register in step with the FSM.
module digit_scan
    import mc14433_pkg::*;
#(
    parameter int SLOT = SLOT_DEF,
    parameter int GAP  = GAP_DEF
) (
    input  logic         cp,
    input  logic         rb,
    digit_scan_if.slave  bus
);

    localparam logic [CNT_W-1:0] SLOT_LD = CNT_W'(SLOT - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP - 1);

    scan_state_t      state;
    scan_state_t      state_nxt;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_tc;

    reading_t         live;
    reading_t         shadow;
    reading_t         disp;
    reading_t         disp_nxt;
    logic             capture;
    logic             stb1_entry;
    logic [3:0]       q_nxt;
    logic [3:0]       ds_nxt;

    assign live = '{
        hd:  bus.hd,
        d3:  bus.d3b,
        d2:  bus.d2b,
        d1:  bus.d1b,
        pol: bus.pol,
        ovf: bus.ovf
    };

    assign capture = bus.eoc & bus.du;

    scan_timer #(
        .W (CNT_W)
    ) u_timer (
        .cp       (cp),
        .rb       (rb),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = SLOT_LD;
        case (state)
            IDLE: begin
                state_nxt = STB1;
                tmr_load  = 1'b1;
            end
            STB1: if (tmr_tc) begin
                state_nxt = GAP1;
                tmr_load  = 1'b1;
                tmr_val   = GAP_LD;
            end
            GAP1: if (tmr_tc) begin
                state_nxt = STB2;
                tmr_load  = 1'b1;
            end
            STB2: if (tmr_tc) begin
                state_nxt = GAP2;
                tmr_load  = 1'b1;
                tmr_val   = GAP_LD;
            end
            GAP2: if (tmr_tc) begin
                state_nxt = STB3;
                tmr_load  = 1'b1;
            end
            STB3: if (tmr_tc) begin
                state_nxt = GAP3;
                tmr_load  = 1'b1;
                tmr_val   = GAP_LD;
            end
            GAP3: if (tmr_tc) begin
                state_nxt = STB4;
                tmr_load  = 1'b1;
            end
            STB4: if (tmr_tc) begin
                state_nxt = GAP4;
                tmr_load  = 1'b1;
                tmr_val   = GAP_LD;
            end
            GAP4: if (tmr_tc) begin
                state_nxt = STB1;
                tmr_load  = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A capture on the STB1 entry edge bypasses the shadow, avoiding a one-frame lag.
    always_comb begin
        stb1_entry = (state_nxt == STB1) && (state != STB1);
        disp_nxt   = disp;
        if (stb1_entry) begin
            disp_nxt = capture ? live : shadow;
        end
    end

    always_comb begin
        q_nxt  = 4'b0000;
        ds_nxt = 4'b0000;
        case (state_nxt)
            STB1: begin
                ds_nxt = 4'b0001;
                q_nxt  = {disp_nxt.hd, disp_nxt.pol, 1'b0, disp_nxt.ovf};
            end
            STB2: begin
                ds_nxt = 4'b0010;
                q_nxt  = disp_nxt.d3;
            end
            STB3: begin
                ds_nxt = 4'b0100;
                q_nxt  = disp_nxt.d2;
            end
            STB4: begin
                ds_nxt = 4'b1000;
                q_nxt  = disp_nxt.d1;
            end
            default: begin
                ds_nxt = 4'b0000;
                q_nxt  = 4'b0000;
            end
        endcase
    end

    // Reset wins over a same-edge capture: the pending reading is dropped.
    always_ff @(posedge cp) begin
        if (!rb) begin
            state   <= IDLE;
            shadow  <= READING_RST;
            disp    <= READING_RST;
            bus.q   <= 4'b0000;
            bus.ds  <= 4'b0000;
            bus.orb <= 1'b1;
            bus.ur  <= 1'b1;
        end else begin
            state   <= state_nxt;
            if (capture) begin
                shadow <= live;
            end
            disp    <= disp_nxt;
            bus.q   <= q_nxt;
            bus.ds  <= ds_nxt;
            bus.orb <= ~disp_nxt.ovf;
            bus.ur  <= is_underrange(disp_nxt);
        end
    end

endmodule

// File: tb/tb_digit_scan.sv
// Scoreboard bench for digit_scan with SLOT=4, GAP=1 (20-cycle frame).
// Stimulus pushes one expected record per strobe; a negedge monitor pops one per strobe onset.
module tb_digit_scan;
    import mc14433_pkg::*;

    localparam int SLOT  = 4;
    localparam int GAP   = 1;
    localparam int FRAME = 4 * (SLOT + GAP);

    logic cp = 1'b0;
    logic rb = 1'b0;

    digit_scan_if bus ();

    digit_scan #(
        .SLOT (SLOT),
        .GAP  (GAP)
    ) dut (
        .cp  (cp),
        .rb  (rb),
        .bus (bus)
    );

    always #5 cp = ~cp;

    typedef struct {
        logic [3:0] ds;
        logic [3:0] q;
        logic       orb;
        logic       ur;
        int         len;
        int         gap;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic reading_t mk(input logic hd, input logic [3:0] d3, input logic [3:0] d2,
                                    input logic [3:0] d1, input logic pol, input logic ovf);
        reading_t r;
        r.hd  = hd;
        r.d3  = d3;
        r.d2  = d2;
        r.d1  = d1;
        r.pol = pol;
        r.ovf = ovf;
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge cp);
        #1;
    endtask

    task automatic drive(input reading_t r);
        bus.hd  = r.hd;
        bus.d3b = r.d3;
        bus.d2b = r.d2;
        bus.d1b = r.d1;
        bus.pol = r.pol;
        bus.ovf = r.ovf;
    endtask

    task automatic push_strobe(input logic [3:0] ds, input logic [3:0] q, input logic orb,
                               input logic ur, input int len, input int gap);
        exp_t e;
        e.ds  = ds;
        e.q   = q;
        e.orb = orb;
        e.ur  = ur;
        e.len = len;
        e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic push_frame(input reading_t r, input logic orb, input logic ur, input int first_gap);
        push_strobe(4'b0001, {r.hd, r.pol, 1'b0, r.ovf}, orb, ur, SLOT, first_gap);
        push_strobe(4'b0010, r.d3, orb, ur, SLOT, GAP);
        push_strobe(4'b0100, r.d2, orb, ur, SLOT, GAP);
        push_strobe(4'b1000, r.d1, orb, ur, SLOT, GAP);
    endtask

    // Called one tick after an STB1 entry edge; optionally pulses EOC on frame cycle cap_at.
    task automatic frame(input reading_t r, input logic orb, input logic ur, input int first_gap,
                         input bit cap, input logic cap_du, input reading_t cin, input int cap_at);
        push_frame(r, orb, ur, first_gap);
        for (int i = 0; i < FRAME; i++) begin
            if (cap && i == cap_at) begin
                drive(cin);
                bus.du  = cap_du;
                bus.eoc = 1'b1;
            end
            step(1);
            bus.eoc = 1'b0;
        end
    endtask

    initial begin : monitor
        logic [3:0] prev_ds;
        int         run;
        int         zrun;
        exp_t       cur;
        bit         cur_ok;
        prev_ds = 4'b0000;
        run     = 0;
        zrun    = 0;
        cur_ok  = 1'b0;
        forever begin
            @(negedge cp);
            if (bus.ds == 4'b0000) begin
                check("blank_q", 32'(bus.q), 32'h0);
            end
            if (bus.ds !== prev_ds) begin
                if (prev_ds != 4'b0000 && cur_ok) begin
                    check("strobe_len", run, cur.len);
                end
                if (bus.ds != 4'b0000) begin
                    if (sb.size() == 0) begin
                        check("unexpected_strobe_queue", sb.size(), 1);
                        cur_ok = 1'b0;
                    end else begin
                        cur    = sb.pop_front();
                        cur_ok = 1'b1;
                        check("ds", 32'(bus.ds), 32'(cur.ds));
                        check("q", 32'(bus.q), 32'(cur.q));
                        check("orb", 32'(bus.orb), 32'(cur.orb));
                        check("ur", 32'(bus.ur), 32'(cur.ur));
                        if (cur.gap >= 0) begin
                            check("gap_len", zrun, cur.gap);
                        end
                    end
                    run = 1;
                end else begin
                    zrun = 1;
                end
            end else if (bus.ds != 4'b0000) begin
                run++;
            end else begin
                zrun++;
            end
            prev_ds = bus.ds;
        end
    end

    initial begin : stimulus
        reading_t rst_rd;
        reading_t a_rd;
        reading_t b_rd;
        reading_t c_rd;
        reading_t d_rd;
        reading_t e_rd;
        reading_t f_rd;
        reading_t g_rd;
        reading_t h_rd;
        reading_t x_rd;

        rst_rd = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        a_rd   = mk(1'b1, 4'd9, 4'd8, 4'd7, 1'b0, 1'b0);
        b_rd   = mk(1'b0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1);
        c_rd   = mk(1'b0, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0);
        d_rd   = mk(1'b0, 4'd1, 4'd5, 4'd0, 1'b1, 1'b1);
        e_rd   = mk(1'b0, 4'd1, 4'd5, 4'd0, 1'b0, 1'b0);
        f_rd   = mk(1'b0, 4'd1, 4'd8, 4'd0, 1'b1, 1'b0);
        g_rd   = mk(1'b0, 4'd1, 4'd7, 4'd9, 1'b1, 1'b0);
        h_rd   = mk(1'b0, 4'hA, 4'hF, 4'hC, 1'b1, 1'b0);
        x_rd   = mk(1'b1, 4'd3, 4'd3, 4'd3, 1'b0, 1'b1);

        bus.eoc = 1'b0;
        bus.du  = 1'b0;
        drive(mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));

        step(3);
        check("rst_q", 32'(bus.q), 32'h0);
        check("rst_ds", 32'(bus.ds), 32'h0);
        check("rst_orb", 32'(bus.orb), 32'h1);
        check("rst_ur", 32'(bus.ur), 32'h1);

        rb = 1'b1;
        step(1);
        // Power-up display, capture A during STB2.
        frame(rst_rd, 1'b1, 1'b1, -1, 1'b1, 1'b1, a_rd, 5);
        // A shown; EOC with DU=0 carrying B must be ignored.
        frame(a_rd, 1'b1, 1'b0, GAP, 1'b1, 1'b0, b_rd, 3);
        frame(a_rd, 1'b1, 1'b0, GAP, 1'b0, 1'b0, rst_rd, 0);
        frame(a_rd, 1'b1, 1'b0, GAP, 1'b0, 1'b0, rst_rd, 0);
        // C captured on the very edge that enters STB1.
        frame(a_rd, 1'b1, 1'b0, GAP, 1'b1, 1'b1, c_rd, FRAME - 1);
        frame(c_rd, 1'b1, 1'b1, GAP, 1'b1, 1'b1, d_rd, 8);
        frame(d_rd, 1'b0, 1'b0, GAP, 1'b1, 1'b1, e_rd, 2);
        frame(e_rd, 1'b1, 1'b1, GAP, 1'b1, 1'b1, f_rd, 10);
        frame(f_rd, 1'b1, 1'b0, GAP, 1'b1, 1'b1, g_rd, 10);
        frame(g_rd, 1'b1, 1'b1, GAP, 1'b1, 1'b1, h_rd, 10);
        frame(h_rd, 1'b1, 1'b0, GAP, 1'b0, 1'b0, rst_rd, 0);

        // Abort during STB3 (after its 2nd cycle) with a capture pending on the reset edge.
        push_strobe(4'b0001, {h_rd.hd, h_rd.pol, 1'b0, h_rd.ovf}, 1'b1, 1'b0, SLOT, GAP);
        push_strobe(4'b0010, h_rd.d3, 1'b1, 1'b0, SLOT, GAP);
        push_strobe(4'b0100, h_rd.d2, 1'b1, 1'b0, 2, GAP);
        step(11);
        rb = 1'b0;
        drive(x_rd);
        bus.du  = 1'b1;
        bus.eoc = 1'b1;
        step(1);
        bus.eoc = 1'b0;
        bus.du  = 1'b0;
        check("abort_ds", 32'(bus.ds), 32'h0);
        check("abort_q", 32'(bus.q), 32'h0);
        check("abort_orb", 32'(bus.orb), 32'h1);
        check("abort_ur", 32'(bus.ur), 32'h1);

        rb = 1'b1;
        step(1);
        push_frame(rst_rd, 1'b1, 1'b1, 1);
        step(FRAME - 1);
        @(negedge cp);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digit_scan.md
DIGIT_SCAN -- requirements
Module: digit_scan

Interface
REQ-001 Parameter SLOT, default 16, clock cycles each digit strobe is held active; legal range 2..255.
REQ-002 Parameter GAP, default 2, blanking cycles after each strobe with all strobes low; legal range 1..15.
REQ-003 CP  input  1  clock; all state changes on rising edge; the block has one clock.
REQ-004 RB  input  1  reset; synchronous and active-low.
REQ-005 EOC  input  1  end-of-conversion pulse from counter control, one cycle wide.
REQ-006 DU  input  1  display-update enable; when low, EOC is ignored.
REQ-007 D1B  input  4  units BCD count.
REQ-008 D2B  input  4  tens BCD count.
REQ-009 D3B  input  4  hundreds BCD count.
REQ-010 HD  input  1  half-digit (thousands) bit from the P1 carry stage.
REQ-011 POL  input  1  sign of the reading; 1 = positive.
REQ-012 OVF  input  1  overflow flag from the counter chain; 1 = count exceeded 1999.
REQ-013 Q  output  4  multiplexed digit data.
REQ-014 DS  output  4  one-hot digit strobes; DS[1] = MSD, DS[4] = LSD.
REQ-015 ORB  output  1  overrange, active-low, from the displayed reading.
REQ-016 UR  output  1  underrange, from the displayed reading.

Function
REQ-017 On a rising edge with EOC=1 and DU=1, HD, D3B, D2B, D1B, POL and OVF SHALL be captured into a shadow register; EOC with DU=0 SHALL leave it unchanged.
REQ-018 The state machine SHALL use states IDLE, STB1..STB4 and GAP1..GAP4, sequenced STB1, GAP1, STB2, GAP2, STB3, GAP3, STB4, GAP4, STB1, and so on indefinitely.
REQ-019 IDLE SHALL last exactly one cycle after reset release and then go to STB1.
REQ-020 Each STBn SHALL last SLOT cycles and each GAPn SHALL last GAP cycles; a frame is 4*(SLOT+GAP) cycles.
REQ-021 Every entry to STB1 SHALL copy the shadow register into the display register.
REQ-022 If a capture (REQ-017) and an STB1 entry occur on the same edge, the newly captured inputs SHALL go directly to the display register; there is no one-frame lag.
REQ-023 DS[n] SHALL be 1 only in STBn; in IDLE and every GAPn, DS SHALL be 0000 and Q SHALL be 0000.
REQ-024 In STB1, Q SHALL be {HD, POL, 0, OVF} from the display register.
REQ-025 In STB2, STB3 and STB4, Q SHALL be hundreds, tens and units respectively, from the display register.
REQ-026 ORB SHALL be 0 exactly while the display OVF=1, independent of the scan phase.
REQ-027 UR SHALL be 1 exactly while the displayed magnitude, HD*1000 + BCD value, is at most 179 and OVF=0.
REQ-028 BCD nibbles above 9 SHALL pass through unchanged; the block performs no range correction.
REQ-029 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-030 While RB=0 at a rising edge, the state SHALL become IDLE and slot counters SHALL clear.
REQ-031 While RB=0 at a rising edge, the shadow and display registers SHALL clear to zero with POL=1 and OVF=0.
REQ-032 While RB=0 at a rising edge, outputs SHALL become Q=0000, DS=0000, ORB=1 and UR=1.
REQ-033 Reset asserted mid-frame SHALL abort the scan on that edge; a pending capture in the same cycle SHALL be discarded.

Structure
REQ-034 The package mc14433_pkg SHALL hold the state enum, the BCD nibble width, the SLOT and GAP defaults, and the underrange threshold 179.
REQ-035 One sub-module, scan_timer, SHALL hold the slot/gap down-counter and provide a terminal-count pulse to the state machine.

Verification (SLOT=4, GAP=1)
REQ-036 Release RB -> IDLE 1 cycle; DS=0001 for 4 cycles, 0000 for 1 cycle, then 0010; the pattern repeats every 20 cycles.
REQ-037 EOC=1, DU=1 with HD=1, D3B=9, D2B=8, D1B=7, POL=0 -> next frame: Q=1000 in STB1, then 1001, 1000, 0111; ORB=1, UR=0.
REQ-038 EOC=1 with DU=0 and new data -> display unchanged over the next 3 frames.
REQ-039 EOC=1, DU=1 on the same edge as STB1 entry with D1B=5 -> that same frame shows Q=0101 in STB4.
REQ-040 Capture OVF=1 -> ORB=0 from the next STB1 entry and Q[0]=1 in STB1; capture 0150 -> UR=1.
REQ-041 RB=0 during STB3 -> on the next edge DS=0000, Q=0000, ORB=1; after release the scan restarts at IDLE, then STB1.
